// File: rtl/sram_stream_port.sv
// sram_stream_port: valid/ready front end for a 1-cycle-latency SRAM macro.
// Credit-gated issue path feeding an in-order {we, data} response FIFO.
module sram_stream_port #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024,
    parameter int RSP_DEPTH  = 2,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);

    logic                  inflight_q;
    logic                  inflight_we_q;
    logic [CW-1:0]         count_q;
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [RSP_DEPTH-1:0][DATA_WIDTH:0] store_q;

    logic push;
    logic pop;
    logic ready;
    int   used;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Credits: queued + in flight, minus the slot freed by this cycle's pop.
    always_comb begin
        pop   = (count_q != '0) & rsp_ready_i;
        used  = int'(count_q) + int'(inflight_q) - int'(pop);
        ready = ~rst_i & (used < RSP_DEPTH);
    end

    assign push         = inflight_q;
    assign req_ready_o  = ready;
    assign sram_req_o   = req_valid_i & ready;
    assign sram_we_o    = req_we_i & sram_req_o;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = sram_we_o ? req_be_i : '0;

    assign rsp_valid_o  = (count_q != '0);
    assign rsp_we_o     = store_q[rptr_q][DATA_WIDTH];
    assign rsp_rdata_o  = store_q[rptr_q][DATA_WIDTH-1:0];

    // Remember what was strobed last cycle so its response lands now.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q    <= 1'b0;
            inflight_we_q <= 1'b0;
        end else begin
            inflight_q    <= sram_req_o;
            inflight_we_q <= sram_we_o;
        end
    end

    // FIFO pointers and occupancy; push/pop together keep count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (push) wptr_q <= bump(wptr_q);
            if (pop) rptr_q <= bump(rptr_q);
            if (push & ~pop) begin
                count_q <= count_q + 1'b1;
            end else if (~push & pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Capture SRAM read data, or a zero-data write ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            store_q <= '0;
        end else if (push) begin
            store_q[wptr_q] <= inflight_we_q ?
                {1'b1, {DATA_WIDTH{1'b0}}} :
                {1'b0, sram_rdata_i};
        end
    end

endmodule

// File: tb/tb_sram_stream_port.sv
// tb_sram_stream_port: two instances (depth 2 and 3) with SRAM models,
// driven by directed and random requests, scored by a queue-based model.
module tb_sram_stream_port;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [BW-1:0] req_be    [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic          rsp_we    [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          sram_req  [2];
    logic          sram_we   [2];
    logic [AW-1:0] sram_addr [2];
    logic [DW-1:0] sram_wdata[2];
    logic [BW-1:0] sram_be   [2];
    logic [DW-1:0] sram_rdata[2];
    logic          pre_en    [2];
    logic [AW-1:0] pre_addr  [2];
    logic [DW-1:0] pre_data  [2];
    logic          rr_mode   [2];
    logic          rr_fix    [2];
    logic          rr_rand   [2];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int D = k + 2;

        logic [DW-1:0] mem     [1024] = '{default: '0};
        logic [DW-1:0] ref_mem [1024] = '{default: '0};
        logic [DW-1:0] mask;
        logic [DW-1:0] merged;
        logic [DW:0]   q  [$];
        int            st [$];

        assign rsp_ready[k] = rr_mode[k] ? rr_rand[k] : rr_fix[k];

        for (genvar b = 0; b < BW; b++) begin : gm
            assign mask[8*b +: 8] = {8{sram_be[k][b]}};
        end
        assign merged = (mem[sram_addr[k]] & ~mask) |
                        (sram_wdata[k] & mask);

        sram_stream_port #(
            .DATA_WIDTH(DW),
            .NUM_WORDS (1024),
            .RSP_DEPTH (D)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[k]),
            .req_ready_o (req_ready[k]),
            .req_we_i    (req_we[k]),
            .req_addr_i  (req_addr[k]),
            .req_wdata_i (req_wdata[k]),
            .req_be_i    (req_be[k]),
            .rsp_valid_o (rsp_valid[k]),
            .rsp_ready_i (rsp_ready[k]),
            .rsp_we_o    (rsp_we[k]),
            .rsp_rdata_o (rsp_rdata[k]),
            .sram_req_o  (sram_req[k]),
            .sram_we_o   (sram_we[k]),
            .sram_addr_o (sram_addr[k]),
            .sram_wdata_o(sram_wdata[k]),
            .sram_be_o   (sram_be[k]),
            .sram_rdata_i(sram_rdata[k])
        );

        // SRAM macro model with 1-cycle read latency, plus ready noise.
        initial forever begin
            @(posedge clk);
            rr_rand[k] <= 1'($urandom);
            if (pre_en[k]) begin
                mem[pre_addr[k]] <= pre_data[k];
            end else if (sram_req[k]) begin
                if (sram_we[k]) mem[sram_addr[k]] <= merged;
                else sram_rdata[k] <= mem[sram_addr[k]];
            end
        end

        // Reference: outstanding list stamped with acceptance cycle.
        initial begin : mon
            int          n;
            int          dummy;
            logic        pop;
            logic        acc;
            logic        ev;
            logic        held_v;
            logic [DW:0] got;
            logic [DW:0] held;
            logic [DW:0] want;
            logic [AW-1:0] a;
            held_v = 1'b0;
            held   = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    st.delete();
                    held_v = 1'b0;
                end else begin
                    n  = q.size();
                    ev = 1'b0;
                    if (n > 0) ev = (cyc - st[0]) >= 2;
                    chk($sformatf("valid%0d", k), rsp_valid[k], ev);
                    got = {rsp_we[k], rsp_rdata[k]};
                    if (held_v) chk($sformatf("hold%0d", k), got, held);
                    pop = rsp_valid[k] && rsp_ready[k];
                    if (pop && n > 0) begin
                        want  = q.pop_front();
                        dummy = st.pop_front();
                        chk($sformatf("rsp%0d", k), got, want);
                    end
                    chk($sformatf("ready%0d", k), req_ready[k],
                        (n - int'(pop)) < D);
                    acc = req_valid[k] && req_ready[k];
                    chk($sformatf("sreq%0d", k), sram_req[k], acc);
                    chk($sformatf("swe%0d", k), sram_we[k],
                        acc && req_we[k]);
                    chk($sformatf("sbe%0d", k), sram_be[k],
                        (acc && req_we[k]) ? req_be[k] : '0);
                    if (acc) begin
                        a = req_addr[k];
                        chk($sformatf("saddr%0d", k), sram_addr[k], a);
                        if (req_we[k]) begin
                            q.push_back({1'b1, {DW{1'b0}}});
                            for (int b = 0; b < BW; b++)
                                if (req_be[k][b])
                                    ref_mem[a][8*b +: 8] =
                                        req_wdata[k][8*b +: 8];
                        end else begin
                            q.push_back({1'b0, ref_mem[a]});
                        end
                        st.push_back(cyc);
                    end
                    chk($sformatf("credit%0d", k), q.size() <= D, 1'b1);
                    held_v = rsp_valid[k] && !rsp_ready[k];
                    held   = got;
                    if (pre_en[k]) ref_mem[pre_addr[k]] = pre_data[k];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int k, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        pre_en[k]   = 1'b1;
        pre_addr[k] = a;
        pre_data[k] = d;
        step();
        pre_en[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, output logic sr,
                        output logic sw, output int waited);
        logic done;
        done      = 1'b0;
        waited    = 0;
        sr        = 1'b0;
        sw        = 1'b0;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_be[k]    = be;
        while (!done) begin
            @(negedge clk);
            done = req_ready[k];
            sr   = sram_req[k];
            sw   = sram_we[k];
            step();
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    chk($sformatf("timeout%0d", k), 1'b0, 1'b1);
                    done = 1'b1;
                end
            end
        end
        req_valid[k] = 1'b0;
    endtask

    task automatic rand_run(input int k, input int n);
        logic sr;
        logic sw;
        int   w;
        rr_mode[k] = 1'b1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            send(k, 1'($urandom), AW'($urandom_range(0, 15)),
                 {$urandom, $urandom}, BW'($urandom), sr, sw, w);
        end
        rr_mode[k] = 1'b0;
        rr_fix[k]  = 1'b1;
        repeat (6) step();
        chk($sformatf("drain%0d", k), rsp_valid[k], 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic sr;
        logic sw;
        int   w;
        int   acc;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_be[k]    = '0;
            pre_en[k]    = 1'b0;
            pre_addr[k]  = '0;
            pre_data[k]  = '0;
            rr_mode[k]   = 1'b0;
            rr_fix[k]    = 1'b1;
        end

        repeat (3) step();
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready[0], 1'b0);
        chk("rst_sreq", sram_req[0], 1'b0);
        req_valid[0] = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", rsp_valid[k], 1'b0);
            chk("rst_we", rsp_we[k], 1'b0);
            chk("rst_rdata", rsp_rdata[k], '0);
            chk("rst_rdy1", req_ready[k], 1'b1);
        end
        step();

        preload(0, 5, 64'hDEAD_BEEF_0000_0005);
        send(0, 1'b0, 5, '0, '0, sr, sw, w);
        chk("rd_sreq", sr, 1'b1);
        chk("rd_swe", sw, 1'b0);
        @(negedge clk);
        chk("rd_early", rsp_valid[0], 1'b0);
        @(negedge clk);
        chk("rd_valid", rsp_valid[0], 1'b1);
        chk("rd_we", rsp_we[0], 1'b0);
        chk("rd_data", rsp_rdata[0], 64'hDEAD_BEEF_0000_0005);
        step();

        send(0, 1'b1, 3, 64'h1122334455667788, 8'h0F, sr, sw, w);
        send(0, 1'b0, 3, '0, 8'hFF, sr, sw, w);
        @(negedge clk);
        chk("wr_ack_v", rsp_valid[0], 1'b1);
        chk("wr_ack_we", rsp_we[0], 1'b1);
        chk("wr_ack_d", rsp_rdata[0], '0);
        @(negedge clk);
        chk("rb_we", rsp_we[0], 1'b0);
        chk("rb_data", rsp_rdata[0], 64'h0000000055667788);
        step();

        for (int i = 0; i < 64; i++)
            preload(0, AW'(i), {$urandom, $urandom});
        for (int i = 0; i < 64; i++) begin
            send(0, 1'b0, AW'(i), '0, '0, sr, sw, w);
            chk("stream_wait", w, 0);
        end
        repeat (4) step();

        rr_fix[0]    = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 7;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            if (c >= 2) chk("bp_ready", req_ready[0], 1'b0);
            step();
        end
        chk("bp_acc", acc, 2);
        rr_fix[0] = 1'b1;
        @(negedge clk);
        chk("bp_pop", rsp_valid[0] && rsp_ready[0], 1'b1);
        chk("bp_take", req_ready[0], 1'b1);
        step();
        rr_fix[0] = 1'b0;
        @(negedge clk);
        chk("bp_full", req_ready[0], 1'b0);
        step();
        req_valid[0] = 1'b0;
        rr_fix[0]    = 1'b1;
        repeat (5) step();

        rand_run(1, 200);
        rand_run(0, 100);

        rr_fix[1] = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1, 1'b0, AW'(i), '0, '0, sr, sw, w);
        rst          = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", req_ready[1], 1'b0);
        chk("mid_rst_sreq", sram_req[1], 1'b0);
        step();
        rst          = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("mid_valid", rsp_valid[1], 1'b0);
        chk("mid_ready", req_ready[1], 1'b1);
        rr_fix[1] = 1'b1;
        repeat (5) step();
        chk("mid_stale", rsp_valid[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
